mem_bus_master: RTL and testbench

Bus initiator that drives the shared memory bus (32-bit `address`, bidirectional 64-bit `data`, `mem_read`/`mem_write` strobes) on behalf of the CPU datapath. It accepts single or burst read/write requests on a valid/ready interface and sequences them onto the bus. Read bursts are pipelined against the synchronous single-port RAM responders; write beats are paced by the requester. The block owns the tri-state drive of `data` on the initiator side and inserts turnaround cycles between transactions.

---
 rtl/mem_bus_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mem_bus_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
//
// Bus initiator for the shared memory bus. Accepts single or burst read/write
// requests on a valid/ready handshake and sequences them onto the bus:
//   - reads are pipelined: one address per cycle, data returns READ_LATENCY
//     cycles later from the synchronous RAM responders;
//   - writes are paced by the requester: one bus beat per accepted wr_data;
//   - every transaction ends with TURNAROUND idle bus cycles before the next
//     request can be accepted.
// The master drives `data` only while mem_write is high.
//
// Parameters
//   READ_LATENCY  bus cycles from read address to valid read data (>=1)
//   TURNAROUND    idle bus cycles after each transaction (>=1)
//   BURST_BITS    width of req_len; bursts are up to 2^BURST_BITS beats
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_write               1 = write burst, 0 = read burst
//   req_addr, req_len       first word address, beats minus one
//   wr_data/wr_valid/wr_ready  write beat handshake
//   rd_data/rd_valid        returned read beats (no backpressure)
//   done                    one-cycle pulse at the start of turnaround
//   address, data           bus address (registered), bidirectional data
//   mem_read, mem_write     registered bus strobes (never both high)
// -----------------------------------------------------------------------------
module mem_bus_master #(
   parameter int READ_LATENCY = 1,
   parameter int TURNAROUND   = 1,
   parameter int BURST_BITS   = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [BURST_BITS-1:0] req_len,
   input  logic [63:0]           wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [63:0]           rd_data,
   output logic                  rd_valid,
   output logic                  done,
   output logic [31:0]           address,
   inout  wire  [63:0]           data,
   output logic                  mem_read,
   output logic                  mem_write
);

   // Read cycle counter must reach (2^BURST_BITS - 1) + READ_LATENCY.
   localparam int CYC_W = BURST_BITS + $clog2(READ_LATENCY + 1) + 1;
   localparam int TRN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

   localparam logic [CYC_W-1:0] RL_C     = CYC_W'(READ_LATENCY);
   localparam logic [TRN_W-1:0] TRN_LAST = TRN_W'(TURNAROUND - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_TURN  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [31:0]           r_base;
   logic [BURST_BITS-1:0] r_len;
   logic [CYC_W-1:0]      r_cyc;     // cycles spent in READ; address i is on the bus in cycle i
   logic [BURST_BITS:0]   r_wcnt;    // write beats accepted so far
   logic [TRN_W-1:0]      r_turn;
   logic [31:0]           r_address;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [63:0]           r_wdata;
   logic [63:0]           r_rd_data;
   logic                  r_rd_valid;
   logic                  r_done;

   logic [31:0]           w_base_nxt;
   logic [BURST_BITS-1:0] w_len_nxt;
   logic [CYC_W-1:0]      w_cyc_nxt;
   logic [BURST_BITS:0]   w_wcnt_nxt;
   logic [TRN_W-1:0]      w_turn_nxt;
   logic [31:0]           w_address_nxt;
   logic                  w_mem_read_nxt;
   logic                  w_mem_write_nxt;
   logic [63:0]           w_wdata_nxt;
   logic [63:0]           w_rd_data_nxt;
   logic                  w_rd_valid_nxt;
   logic                  w_done_nxt;

   logic [CYC_W-1:0]      w_len_ext;
   logic                  w_req_ready;
   logic                  w_req_fire;
   logic                  w_last_issue;
   logic                  w_sample;
   logic                  w_last_sample;
   logic                  w_beats_left;
   logic                  w_wr_fire;

   // Ready is masked by reset so the handshake stays closed while reset is held.
   assign w_req_ready   = (r_state == S_IDLE) && !reset;
   assign w_req_fire    = req_valid && w_req_ready;

   assign w_len_ext     = CYC_W'(r_len);
   assign w_last_issue  = (r_cyc >= w_len_ext);
   assign w_sample      = (r_cyc >= RL_C);
   assign w_last_sample = (r_cyc == (w_len_ext + RL_C));

   assign w_beats_left  = (r_wcnt <= {1'b0, r_len});
   assign w_wr_fire     = (r_state == S_WRITE) && wr_valid && w_beats_left;

   // The master owns the data lines only during its own write beats.
   assign data = r_mem_write ? r_wdata : {64{1'bz}};

   assign address   = r_address;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign done      = r_done;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_fire) begin
               w_state_nxt = req_write ? S_WRITE : S_READ;
            end
         end
         S_READ: begin
            if (w_last_sample) begin
               w_state_nxt = S_TURN;
            end
         end
         S_WRITE: begin
            // No beats left means the last beat is on the bus right now.
            if (!w_beats_left) begin
               w_state_nxt = S_TURN;
            end
         end
         S_TURN: begin
            if (r_turn == TRN_LAST) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: handshake outputs and next values of the bus registers
   always_comb begin
      req_ready       = w_req_ready;
      wr_ready        = (r_state == S_WRITE) && w_beats_left;

      w_base_nxt      = r_base;
      w_len_nxt       = r_len;
      w_cyc_nxt       = r_cyc;
      w_wcnt_nxt      = r_wcnt;
      w_turn_nxt      = '0;
      w_address_nxt   = r_address;
      w_mem_read_nxt  = 1'b0;
      w_mem_write_nxt = 1'b0;
      w_wdata_nxt     = r_wdata;
      w_rd_data_nxt   = r_rd_data;
      w_rd_valid_nxt  = 1'b0;
      w_done_nxt      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_req_fire) begin
               w_base_nxt = req_addr;
               w_len_nxt  = req_len;
               w_cyc_nxt  = '0;
               w_wcnt_nxt = '0;
               // A read puts its first address on the bus right away.
               if (!req_write) begin
                  w_address_nxt  = req_addr;
                  w_mem_read_nxt = 1'b1;
               end
            end
         end
         S_READ: begin
            w_cyc_nxt      = r_cyc + CYC_W'(1);
            w_mem_read_nxt = !w_last_sample;
            // After the last address, hold it until the pipeline drains.
            if (!w_last_issue) begin
               w_address_nxt = r_address + 32'd1;
            end
            if (w_sample) begin
               w_rd_data_nxt  = data;
               w_rd_valid_nxt = 1'b1;
            end
            if (w_last_sample) begin
               w_done_nxt = 1'b1;
            end
         end
         S_WRITE: begin
            if (w_wr_fire) begin
               w_address_nxt   = r_base + 32'(r_wcnt);
               w_wdata_nxt     = wr_data;
               w_mem_write_nxt = 1'b1;
               w_wcnt_nxt      = r_wcnt + {{BURST_BITS{1'b0}}, 1'b1};
            end
            if (!w_beats_left) begin
               w_done_nxt = 1'b1;
            end
         end
         S_TURN: begin
            w_turn_nxt = r_turn + TRN_W'(1);
         end
         default: begin
         end
      endcase
   end

   // Bus strobes, address and read return: cleared by reset
   always_ff @(posedge clock) begin
      if (reset) begin
         r_address   <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_address   <= w_address_nxt;
         r_mem_read  <= w_mem_read_nxt;
         r_mem_write <= w_mem_write_nxt;
         r_rd_data   <= w_rd_data_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Transaction context: reloaded on every acceptance, so no reset needed
   always_ff @(posedge clock) begin
      r_base  <= w_base_nxt;
      r_len   <= w_len_nxt;
      r_cyc   <= w_cyc_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_turn  <= w_turn_nxt;
      r_wdata <= w_wdata_nxt;
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// Testbench for mem_bus_master: a synchronous RAM responder on the bus, a
// cycle-indexed expectation timeline filled from the transaction rules, and one
// compare process checking every cycle, plus literal pins on key results.
module tb_mem_bus_master;
   localparam int RL   = 1;
   localparam int TA   = 1;
   localparam int BB   = 3;
   localparam int NCYC = 1024;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [BB-1:0] req_len = '0;
   logic [63:0]   wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          req_ready, wr_ready, rd_valid, done, mem_read, mem_write;
   logic [63:0]   rd_data;
   logic [31:0]   address;
   wire  [63:0]   data;

   mem_bus_master #(.READ_LATENCY(RL), .TURNAROUND(TA), .BURST_BITS(BB)) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
      .address(address), .data(data),
      .mem_read(mem_read), .mem_write(mem_write)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // RAM responder (latency 1): small array with a collision-free index for the
   // address ranges used here.
   logic [63:0] ram [64];
   logic [63:0] ram_q;
   logic        ram_oe = 1'b0;
   function automatic logic [5:0] ram_idx(input logic [31:0] a);
      return a[5:0] ^ {a[17:16], 4'b0000};
   endfunction
   always @(posedge clock) begin
      ram_oe <= mem_read;
      if (mem_read) ram_q <= ram[ram_idx(address)];
      if (mem_write) ram[ram_idx(address)] <= data;
   end
   assign data = ram_oe ? ram_q : {64{1'bz}};

   // Bus monitor logs
   int          mr_cnt = 0, rv_cnt = 0, dn_cnt = 0;
   logic [31:0] mr_addr_q[$];
   logic [31:0] mw_addr_q[$];
   logic [63:0] mw_data_q[$];
   int          mw_cyc_q[$];
   logic [63:0] rd_q[$];
   always @(negedge clock) begin
      if (mem_read) begin
         mr_cnt <= mr_cnt + 1;
         mr_addr_q.push_back(address);
      end
      if (mem_write) begin
         mw_addr_q.push_back(address);
         mw_data_q.push_back(data);
         mw_cyc_q.push_back(cyc);
      end
      if (rd_valid) begin
         rv_cnt <= rv_cnt + 1;
         rd_q.push_back(rd_data);
      end
      if (done) dn_cnt <= dn_cnt + 1;
   end

   // Behavioural model: memory contents plus a per-cycle expected timeline
   logic [63:0] mdl [logic [31:0]];
   bit          exp_mr [NCYC];
   bit          exp_mw [NCYC];
   bit          exp_rv [NCYC];
   bit          exp_dn [NCYC];
   bit          exp_wr [NCYC];
   bit          exp_busy [NCYC];
   logic [31:0] exp_ad [NCYC];
   logic [63:0] exp_wd [NCYC];
   logic [63:0] exp_rd [NCYC];
   logic [63:0] wbeat [8];

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] mdl_get(input logic [31:0] a);
      return mdl.exists(a) ? mdl[a] : 64'h0;
   endfunction

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clock); #1;
      end
   endtask

   // Present a request; returns the cycle index that starts after the accepting edge.
   task automatic issue(input logic wr, input logic [31:0] a, input int n, output int e0);
      int t;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_len = BB'(n - 1);
      t = 0;
      @(negedge clock);
      while (!req_ready && t < 50) begin
         @(negedge clock); t++;
      end
      chk("accept_ready", {63'd0, req_ready}, 64'd1);
      @(posedge clock); #1;
      e0 = cyc;
      req_valid = 1'b0;
   endtask

   task automatic set_read_exp(input logic [31:0] a, input int n, input int e0);
      for (int k = e0; k < e0 + n + RL; k++) begin
         exp_mr[k] = 1'b1;
         exp_ad[k] = a + 32'((k - e0 < n) ? (k - e0) : (n - 1));
      end
      for (int i = 0; i < n; i++) begin
         exp_rv[e0 + i + RL + 1] = 1'b1;
         exp_rd[e0 + i + RL + 1] = mdl_get(a + 32'(i));
      end
      exp_dn[e0 + n + RL] = 1'b1;
      for (int k = e0; k < e0 + n + RL + TA; k++) exp_busy[k] = 1'b1;
   endtask

   task automatic do_read(input logic [31:0] a, input int n);
      int e0;
      issue(1'b0, a, n, e0);
      set_read_exp(a, n, e0);
      wait_to(e0 + n + RL + TA);
   endtask

   // stall_at: beat index before which wr_valid drops for stall_len cycles (-1: none)
   task automatic do_write(input logic [31:0] a, input int n, input int stall_at, input int stall_len);
      int e0, k, stalled, last;
      issue(1'b1, a, n, e0);
      k = 0; stalled = 0;
      while (k < n) begin
         exp_busy[cyc] = 1'b1;
         exp_wr[cyc] = 1'b1;
         if (k == stall_at && stalled < stall_len) begin
            wr_valid = 1'b0;
            stalled++;
         end else begin
            wr_valid = 1'b1;
            wr_data = wbeat[k];
            exp_mw[cyc + 1] = 1'b1;
            exp_ad[cyc + 1] = a + 32'(k);
            exp_wd[cyc + 1] = wbeat[k];
            mdl[a + 32'(k)] = wbeat[k];
            k++;
         end
         @(posedge clock); #1;
      end
      wr_valid = 1'b0;
      last = cyc;
      exp_dn[last + 1] = 1'b1;
      for (int c = last; c <= last + TA; c++) exp_busy[c] = 1'b1;
      wait_to(last + TA + 1);
   endtask

   logic [31:0] wrap_addr [4];
   int dn0, rv0, mr0, rq, mwi, mri, e0r;

   initial begin
      fork
         begin : compare_proc
            forever begin
               @(negedge clock);
               if (cyc >= NCYC) begin
                  $display("FAIL cycle_budget at cycle %0d: got over, want under %0d", cyc, NCYC);
                  $fatal(1);
               end
               if (chk_en) begin
                  chk("mem_read",  {63'd0, mem_read},  {63'd0, exp_mr[cyc]});
                  chk("mem_write", {63'd0, mem_write}, {63'd0, exp_mw[cyc]});
                  chk("rd_valid",  {63'd0, rd_valid},  {63'd0, exp_rv[cyc]});
                  chk("done",      {63'd0, done},      {63'd0, exp_dn[cyc]});
                  chk("wr_ready",  {63'd0, wr_ready},  {63'd0, exp_wr[cyc]});
                  chk("req_ready", {63'd0, req_ready}, {63'd0, !reset && !exp_busy[cyc]});
                  chk("strobe_excl", {63'd0, mem_read & mem_write}, 64'd0);
                  if (exp_mr[cyc] || exp_mw[cyc]) chk("address", {32'd0, address}, {32'd0, exp_ad[cyc]});
                  if (exp_mw[cyc]) chk("bus_wdata", data, exp_wd[cyc]);
                  if (exp_rv[cyc]) chk("rd_data", rd_data, exp_rd[cyc]);
               end
            end
         end
         begin : watchdog
            #200000;
            $display("FAIL watchdog: got timeout, want completion");
            $fatal(1);
         end
      join_none

      // Reset values
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_address",   {32'd0, address},    64'd0);
      chk("rst_mem_read",  {63'd0, mem_read},   64'd0);
      chk("rst_mem_write", {63'd0, mem_write},  64'd0);
      chk("rst_rd_valid",  {63'd0, rd_valid},   64'd0);
      chk("rst_rd_data",   rd_data,             64'd0);
      chk("rst_done",      {63'd0, done},       64'd0);
      chk("rst_wr_ready",  {63'd0, wr_ready},   64'd0);
      chk("rst_req_ready", {63'd0, req_ready},  64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
      chk_en = 1'b1;
      @(posedge clock); #1;

      // Single write then single read of the same word
      wbeat[0] = 64'hDEADBEEF_CAFEF00D;
      dn0 = dn_cnt; rv0 = rv_cnt; mwi = mw_addr_q.size();
      do_write(32'h0002_0004, 1, -1, 0);
      do_read(32'h0002_0004, 1);
      chk("single_wr_addr", {32'd0, mw_addr_q[mwi]}, 64'h0002_0004);
      chk("single_wr_data", mw_data_q[mwi], 64'hDEADBEEF_CAFEF00D);
      chk("single_rd_data", rd_q[rd_q.size() - 1], 64'hDEADBEEF_CAFEF00D);
      chk("single_rv_count", 64'(rv_cnt - rv0), 64'd1);
      chk("single_done_count", 64'(dn_cnt - dn0), 64'd2);

      // 8-beat write then 8-beat read
      for (int i = 0; i < 8; i++) wbeat[i] = 64'(i) * 64'h11;
      do_write(32'h0002_0000, 8, -1, 0);
      mr0 = mr_cnt; rv0 = rv_cnt; rq = rd_q.size();
      do_read(32'h0002_0000, 8);
      chk("burst_mem_read_cycles", 64'(mr_cnt - mr0), 64'd9);
      chk("burst_rv_count", 64'(rv_cnt - rv0), 64'd8);
      for (int i = 0; i < 8; i++) chk("burst_rd_beat", rd_q[rq + i], 64'(i) * 64'h11);

      // Write burst with wr_valid dropped for 2 cycles before beat 2
      for (int i = 0; i < 4; i++) wbeat[i] = 64'hA0 + 64'(i);
      mwi = mw_addr_q.size();
      do_write(32'h0003_0000, 4, 2, 2);
      chk("stall_gap", 64'(mw_cyc_q[mwi + 2] - mw_cyc_q[mwi + 1]), 64'd3);
      chk("stall_beats", 64'(mw_addr_q.size() - mwi), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("stall_addr", {32'd0, mw_addr_q[mwi + i]}, 64'h0003_0000 + 64'(i));
         chk("stall_data", mw_data_q[mwi + i], 64'hA0 + 64'(i));
      end
      do_read(32'h0003_0000, 4);

      // Address wrap at the top of the 32-bit space
      for (int i = 0; i < 4; i++) wbeat[i] = 64'h5A5A_0000_0000_0000 + 64'(i);
      do_write(32'hFFFF_FFFE, 4, -1, 0);
      mri = mr_addr_q.size();
      do_read(32'hFFFF_FFFE, 4);
      wrap_addr[0] = 32'hFFFF_FFFE; wrap_addr[1] = 32'hFFFF_FFFF;
      wrap_addr[2] = 32'h0000_0000; wrap_addr[3] = 32'h0000_0001;
      for (int i = 0; i < 4; i++) chk("wrap_addr", {32'd0, mr_addr_q[mri + i]}, {32'd0, wrap_addr[i]});

      // Reset during the third beat of an 8-beat read
      issue(1'b0, 32'h0002_0000, 8, e0r);
      set_read_exp(32'h0002_0000, 8, e0r);
      wait_to(e0r + 2);
      reset = 1'b1;
      for (int k = e0r + 3; k < NCYC; k++) begin
         exp_mr[k] = 1'b0; exp_mw[k] = 1'b0; exp_rv[k] = 1'b0;
         exp_dn[k] = 1'b0; exp_wr[k] = 1'b0; exp_busy[k] = 1'b0;
      end
      @(posedge clock); #1;
      reset = 1'b0;
      rv0 = rv_cnt; dn0 = dn_cnt;
      repeat (4) begin
         @(posedge clock); #1;
      end
      chk("rst_mid_no_rv", 64'(rv_cnt - rv0), 64'd0);
      chk("rst_mid_no_done", 64'(dn_cnt - dn0), 64'd0);

      // Fresh request after reset
      rv0 = rv_cnt;
      do_read(32'h0002_0004, 1);
      chk("post_rst_rv_count", 64'(rv_cnt - rv0), 64'd1);
      chk("post_rst_rd_data", rd_q[rd_q.size() - 1], 64'h44);

      repeat (2) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
